sram_bus_responder: RTL and testbench
=====================================

// Module: sram_bus_responder
// PURPOSE
//  Word-organised on-chip SRAM that answers the CPU memory bus on the responder side.
//  The CPU drives read/write strobes, address, write data and access size. This block returns
//  read data plus a one-cycle ready/error response after a programmable number of wait states.
//  Instanced by the MCU top next to the other bus responders; BASE_ADDR selects its decode window.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte address of word 0; must be 4-byte aligned
//  DEPTH_WORDS  1024           number of 32-bit words; power of two
//  WAIT_STATES  0              extra cycles between accept and response (0..15)
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  rst      in   1   reset, asynchronous, active-low
//  rd_req   in   1   CPU read strobe, held until rdy
//  wr_req   in   1   CPU write strobe, held until rdy
//  addr     in   32  byte address
//  size     in   2   access size: 00 byte, 01 half, 10 word, 11 reserved
//  wdata    in   32  write data, right-justified for byte/half
//  rdata    out  32  read data, zero-extended, valid only while rdy=1
//  rdy      out  1   one-cycle response pulse; ends the access
//  err      out  1   qualifies rdy: access rejected, no side effect
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; rdy=0, err=0, rdata=0; wait counter=0. SRAM contents are not cleared.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. WAIT is skipped when WAIT_STATES=0.
//  - IDLE: if rd_req|wr_req is high, latch addr/size/wdata/op and the error decision, then leave IDLE.
//  - WAIT: counter loads WAIT_STATES-1 on accept and decrements; go to RESP when it reaches 0.
//  - RESP: rdy=1 for exactly one cycle; then IDLE.
//  - Latency: rdy rises WAIT_STATES+1 cycles after the accepting edge. Minimum 2 cycles per access.
//  - Strobe protocol: CPU deasserts strobes in the cycle after rdy. IDLE re-samples on the next edge.
//    Strobe changes after accept are ignored (request is latched).
//  - Error (err=1 with rdy, no write performed, rdata=0) when any of these holds:
//    rd_req&wr_req both high; size=11; addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS;
//    half with addr[0]=1; word with addr[1:0]!=00.
//  - Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits after the range check.
//  - Little-endian lanes: a byte uses lane addr[1:0]; a half uses bytes {addr[1],0} and {addr[1],1}.
//  - Read: select the lane(s) and zero-extend into rdata[7:0] or rdata[15:0].
//  - Write: read-modify-write merge of only the addressed lane(s); other bytes unchanged.
//    The write commits on the RESP edge.
//  - Read data is sampled from the array on the RESP edge. A write is visible to the next access.
//  - Reset mid-access: the access is aborted; a write whose RESP edge has not occurred is not performed.
//  - err and rdata are 0 whenever rdy=0.
// STRUCTURE
//  - Package mem_bus_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD localparams and the state encoding
//    (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), shared with the CPU and the other responders.
//  - Sub-module byte_lane_unit (combinational): inputs size, addr[1:0], wdata, old word.
//    Outputs merged write word, extracted read data and misalign flag.
//  - The top holds the FSM, wait counter, request latches, range check and array.
// TESTING
//  1 Reset: hold rst=0 with rd_req=1 -> rdy=0, err=0, rdata=0. Release -> first access accepted next edge.
//  2 Word write then read, WAIT_STATES=0: wr 0x10 <- 32'hDEADBEEF, then rd 0x10.
//    -> rdata=32'hDEADBEEF, err=0, rdy 1 cycle after accept.
//  3 Byte/half lanes: word 0x20=32'h11223344; wr byte 0x21 <- 8'hAA.
//    -> rd word 0x20 = 32'h1122AA44; rd half 0x22 = 32'h00001122.
//  4 Errors: half at 0x23, word at 0x22, size=11, addr=BASE_ADDR+4*DEPTH_WORDS, rd&wr together.
//    -> each gives rdy=1, err=1, rdata=0; word 0x20 is unchanged afterwards.
//  5 Wait states (WAIT_STATES=3): rd accepted at edge N -> rdy high only in the cycle after edge N+4.
//    Toggling wr_req during WAIT has no effect.
//  6 Reset mid-access (WAIT_STATES=3): wr 0x30 <- 32'h5, assert rst during WAIT.
//    -> rdy never pulses; subsequent rd 0x30 returns the old value.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the CPU memory bus: access-size encodings and the
// responder state encoding. The CPU and the other bus responders import it too.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    typedef logic [1:0] bus_size_t;
    typedef logic [1:0] bus_state_t;

    localparam bus_size_t SIZE_BYTE = 2'b00;
    localparam bus_size_t SIZE_HALF = 2'b01;
    localparam bus_size_t SIZE_WORD = 2'b10;
    localparam bus_size_t SIZE_RSVD = 2'b11;

    localparam bus_state_t ST_IDLE = 2'd0;
    localparam bus_state_t ST_WAIT = 2'd1;
    localparam bus_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/byte_lane_unit.sv
// -----------------------------------------------------------------------------
// byte_lane_unit
// Combinational little-endian lane steering for one 32-bit SRAM word.
// Ports:
//   size_i      access size (byte/half/word; reserved gives no enables)
//   lane_i      addr[1:0] of the access
//   wdata_i     right-justified write data from the bus
//   old_word_i  current contents of the addressed word
//   merged_o    old word with only the addressed byte lanes replaced
//   rdata_o     addressed lane(s), zero-extended and right-justified
//   misalign_o  half on an odd address or word not on a 4-byte boundary
// -----------------------------------------------------------------------------
module byte_lane_unit
    import mem_bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_word_i,
    output logic [31:0] merged_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [3:0]  be;
    logic [31:0] wdata_sh;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    // Shifting the whole word right by the lane offset puts the addressed
    // byte/half at bit 0, so extraction is just a mask afterwards.
    assign byte_sh = old_word_i >> {lane_i, 3'b000};
    assign half_sh = old_word_i >> {lane_i[1], 4'b0000};

    always_comb begin
        be         = 4'b0000;
        wdata_sh   = wdata_i;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                be       = 4'b0001 << lane_i;
                wdata_sh = wdata_i << {lane_i, 3'b000};
                rdata_o  = {24'h0, byte_sh[7:0]};
            end
            SIZE_HALF: begin
                be         = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_sh   = wdata_i << {lane_i[1], 4'b0000};
                rdata_o    = {16'h0, half_sh[15:0]};
                misalign_o = lane_i[0];
            end
            SIZE_WORD: begin
                be         = 4'b1111;
                rdata_o    = old_word_i;
                misalign_o = (lane_i != 2'b00);
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_o[8*gi +: 8] = be[gi] ? wdata_sh[8*gi +: 8] : old_word_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/sram_bus_responder.sv
// -----------------------------------------------------------------------------
// sram_bus_responder
// Word-organised on-chip SRAM answering CPU bus accesses with a one-cycle
// ready/error pulse after WAIT_STATES extra cycles.
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   rd_req_i, wr_req_i  CPU strobes, held until rdy_o
//   addr_i              byte address
//   size_i              00 byte, 01 half, 10 word, 11 reserved
//   wdata_i             right-justified write data
//   rdata_o             zero-extended read data, 0 unless rdy_o
//   rdy_o               one-cycle response pulse
//   err_o               access rejected (only with rdy_o)
// -----------------------------------------------------------------------------
module sram_bus_responder
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req_i,
    input  logic        wr_req_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rdy_o,
    output logic        err_o
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    bus_state_t         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         lane_q;
    logic [1:0]         size_q;
    logic [31:0]        wdata_q;
    logic               wr_q;
    logic               req_err_q;
    logic               rdy_q;
    logic               rerr_q;
    logic [31:0]        rdata_q;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        ram_q;

    logic               accept;
    logic [32:0]        offset;
    logic               in_range;
    logic               req_err;
    logic [IDX_W-1:0]   idx_in;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        merged;
    logic [31:0]        lane_rdata;
    logic               misalign;
    logic               resp_err;
    logic               do_write;

    // Nothing is accepted in the rdy cycle itself: the CPU still holds its
    // strobes on that edge and drops them only afterwards.
    assign accept = (state_q == ST_IDLE) && !rdy_q && (rd_req_i || wr_req_i);

    // 33-bit subtraction: the borrow bit flags addresses below the window.
    assign offset   = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    assign in_range = !offset[32] && (offset < SPAN);
    assign idx_in   = IDX_W'(offset >> 2);
    assign req_err  = (rd_req_i && wr_req_i) || (size_i == SIZE_RSVD) || !in_range;

    // While idle the RAM is read at the incoming address so the word is
    // already registered when the RESP edge arrives, even with no wait states.
    assign rd_idx = (state_q == ST_IDLE) ? idx_in : idx_q;

    byte_lane_unit u_lanes (
        .size_i     (size_q),
        .lane_i     (lane_q),
        .wdata_i    (wdata_q),
        .old_word_i (ram_q),
        .merged_o   (merged),
        .rdata_o    (lane_rdata),
        .misalign_o (misalign)
    );

    // Alignment is judged from the latched request, so it is part of the
    // same decision made at accept time.
    assign resp_err = req_err_q || misalign;
    assign do_write = (state_q == ST_RESP) && wr_q && !resp_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            lane_q    <= 2'b00;
            size_q    <= SIZE_BYTE;
            wdata_q   <= 32'h0;
            wr_q      <= 1'b0;
            req_err_q <= 1'b0;
            rdy_q     <= 1'b0;
            rerr_q    <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q     <= idx_in;
                lane_q    <= addr_i[1:0];
                size_q    <= size_i;
                wdata_q   <= wdata_i;
                wr_q      <= wr_req_i;
                req_err_q <= req_err;
            end
            if (state_q == ST_RESP) begin
                rdy_q   <= 1'b1;
                rerr_q  <= resp_err;
                rdata_q <= (resp_err || wr_q) ? 32'h0 : lane_rdata;
            end else begin
                rdy_q   <= 1'b0;
                rerr_q  <= 1'b0;
                rdata_q <= 32'h0;
            end
        end
    end

    // Array and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx_q] <= merged;
        end
        ram_q <= mem[rd_idx];
    end

    assign rdy_o   = rdy_q;
    assign err_o   = rerr_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_sram_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_bus_responder
// Two responders (no wait states / three wait states, different windows) on
// one clock. A byte-addressed reference memory predicts every response.
// -----------------------------------------------------------------------------
module tb_sram_bus_responder;

    localparam logic [31:0] BASE0  = 32'h0000_0000;
    localparam int          DEPTH0 = 256;
    localparam logic [31:0] BASE1  = 32'h0000_2000;
    localparam int          DEPTH1 = 64;

    logic        clk;
    logic        rst_n;
    logic        rd_req  [2];
    logic        wr_req  [2];
    logic [31:0] addr    [2];
    logic [1:0]  size    [2];
    logic [31:0] wdata   [2];
    logic [31:0] rdata_w [2];
    logic        rdy_w   [2];
    logic        err_w   [2];

    int errors = 0;
    int checks = 0;
    int ntxn   = 0;

    logic [7:0] mdl [bit [32:0]];

    sram_bus_responder #(.BASE_ADDR(BASE0), .DEPTH_WORDS(DEPTH0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rd_req_i(rd_req[0]), .wr_req_i(wr_req[0]),
        .addr_i(addr[0]), .size_i(size[0]), .wdata_i(wdata[0]),
        .rdata_o(rdata_w[0]), .rdy_o(rdy_w[0]), .err_o(err_w[0])
    );

    sram_bus_responder #(.BASE_ADDR(BASE1), .DEPTH_WORDS(DEPTH1), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_req_i(rd_req[1]), .wr_req_i(wr_req[1]),
        .addr_i(addr[1]), .size_i(size[1]), .wdata_i(wdata[1]),
        .rdata_o(rdata_w[1]), .rdy_o(rdy_w[1]), .err_o(err_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? DEPTH0 : DEPTH1;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: memory is a flat byte array; an access touches n consecutive
    // byte addresses starting at addr, assembled little-endian.
    function automatic void model(input int d, input bit rd, input bit wr,
                                  input logic [31:0] a, input logic [1:0] sz,
                                  input logic [31:0] wd,
                                  output bit e, output logic [31:0] rv);
        longint unsigned lo, hi;
        int n;
        bit mis;
        lo  = longint'(base_of(d));
        hi  = lo + 4 * depth_of(d);
        n   = (sz == 2'b11) ? 0 : (1 << sz);
        mis = (n != 0) && ((a % n) != 0);
        e   = (rd && wr) || (n == 0) || (longint'(a) < lo) || (longint'(a) >= hi) || mis;
        rv  = 32'h0;
        if (!e) begin
            for (int k = 0; k < n; k++) begin
                if (rd) rv = rv | (32'(mdl[{d[0], a + 32'(k)}]) << (8 * k));
                if (wr) mdl[{d[0], a + 32'(k)}] = wd[8*k +: 8];
            end
        end
    endfunction

    // Called just after a falling edge. Returns the response seen, the number
    // of falling edges until rdy, and rdy one cycle later.
    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] wd, input bit tog,
                          output bit gr, output logic ge, output logic [31:0] gd,
                          output int lat, output logic after);
        rd_req[d] = rd; wr_req[d] = wr; addr[d] = a; size[d] = sz; wdata[d] = wd;
        gr = 1'b0; ge = 1'b0; gd = 32'h0; lat = 0; after = 1'b0;
        for (int i = 1; i <= 40 && !gr; i++) begin
            @(negedge clk);
            if (rdy_w[d]) begin
                gr = 1'b1; lat = i; ge = err_w[d]; gd = rdata_w[d];
            end else if (tog) begin
                wr_req[d] = ~wr_req[d];
                wdata[d]  = $urandom;
            end
        end
        rd_req[d] = 1'b0; wr_req[d] = 1'b0;
        @(negedge clk);
        after = rdy_w[d];
    endtask

    task automatic txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] wd, input bit tog,
                       output logic [31:0] got);
        bit e; logic [31:0] ev; bit gr; logic ge; logic [31:0] gd; int lat; logic after;
        model(d, rd, wr, a, sz, wd, e, ev);
        access(d, rd, wr, a, sz, wd, tog, gr, ge, gd, lat, after);
        ntxn++;
        got = gd;
        $display("txn %0d dut%0d rd=%0d wr=%0d addr=%h size=%0d wdata=%h -> rdy=%0d err=%0d rdata=%h lat=%0d",
                 ntxn, d, rd, wr, a, sz, wd, gr, ge, gd, lat);
        chk($sformatf("t%0d_rdy", ntxn), 32'(gr), 32'd1);
        if (gr) begin
            chk($sformatf("t%0d_latency", ntxn), 32'(lat), 32'(ws_of(d) + 2));
            chk($sformatf("t%0d_err", ntxn), 32'(ge), 32'(e));
            if (rd || e) chk($sformatf("t%0d_rdata", ntxn), gd, ev);
            chk($sformatf("t%0d_rdy_width", ntxn), 32'(after), 32'd0);
        end
    endtask

    initial begin
        bit gr0, gr1; logic ge0, ge1, af0, af1; logic [31:0] gd0, gd1, got; int lat0, lat1;
        bit seen; int d; logic [31:0] a; logic [1:0] sz; bit rd, wr;

        for (int i = 0; i < 2; i++) begin
            rd_req[i] = 1'b0; wr_req[i] = 1'b0; addr[i] = 32'h0; size[i] = 2'b10; wdata[i] = 32'h0;
        end

        // Reset held with a read strobe pending: outputs quiet.
        rst_n = 1'b0;
        rd_req[0] = 1'b1; addr[0] = BASE0 + 32'h10;
        rd_req[1] = 1'b1; addr[1] = BASE1 + 32'h10;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_rdy%0d", i), 32'(rdy_w[i]), 32'd0);
            chk($sformatf("reset_err%0d", i), 32'(err_w[i]), 32'd0);
            chk($sformatf("reset_rdata%0d", i), rdata_w[i], 32'h0);
        end
        rst_n = 1'b1;
        fork
            access(0, 1'b1, 1'b0, BASE0 + 32'h10, 2'b10, 32'h0, 1'b0, gr0, ge0, gd0, lat0, af0);
            access(1, 1'b1, 1'b0, BASE1 + 32'h10, 2'b10, 32'h0, 1'b0, gr1, ge1, gd1, lat1, af1);
        join
        $display("txn post-reset: dut0 rdy=%0d lat=%0d, dut1 rdy=%0d lat=%0d", gr0, lat0, gr1, lat1);
        chk("post_reset_lat0", 32'(lat0), 32'd2);
        chk("post_reset_lat1", 32'(lat1), 32'd5);
        chk("post_reset_err0", 32'(ge0), 32'd0);
        chk("post_reset_err1", 32'(ge1), 32'd0);

        // Fill the first 16 words of each window so every later read is defined.
        for (int di = 0; di < 2; di++)
            for (int w = 0; w < 16; w++)
                txn(di, 1'b0, 1'b1, base_of(di) + 32'(4 * w), 2'b10, $urandom, 1'b0, got);

        // Word write then read back.
        txn(0, 1'b0, 1'b1, 32'h10, 2'b10, 32'hDEADBEEF, 1'b0, got);
        txn(0, 1'b1, 1'b0, 32'h10, 2'b10, 32'h0, 1'b0, got);
        chk("word_readback", got, 32'hDEADBEEF);

        // Byte and half lanes.
        txn(0, 1'b0, 1'b1, 32'h20, 2'b10, 32'h11223344, 1'b0, got);
        txn(0, 1'b0, 1'b1, 32'h21, 2'b00, 32'h000000AA, 1'b0, got);
        txn(0, 1'b1, 1'b0, 32'h20, 2'b10, 32'h0, 1'b0, got);
        chk("byte_merge", got, 32'h1122AA44);
        txn(0, 1'b1, 1'b0, 32'h22, 2'b01, 32'h0, 1'b0, got);
        chk("half_read", got, 32'h00001122);

        // Rejected accesses, none of which may touch word 0x20.
        txn(0, 1'b0, 1'b1, 32'h23, 2'b01, 32'hFFFFFFFF, 1'b0, got);
        txn(0, 1'b0, 1'b1, 32'h22, 2'b10, 32'hFFFFFFFF, 1'b0, got);
        txn(0, 1'b0, 1'b1, 32'h20, 2'b11, 32'hFFFFFFFF, 1'b0, got);
        txn(0, 1'b1, 1'b0, BASE0 + 32'(4 * DEPTH0), 2'b10, 32'h0, 1'b0, got);
        txn(0, 1'b1, 1'b1, 32'h20, 2'b10, 32'hFFFFFFFF, 1'b0, got);
        txn(1, 1'b0, 1'b1, BASE1 - 32'h4, 2'b10, 32'hFFFFFFFF, 1'b0, got);
        txn(1, 1'b1, 1'b0, BASE1 + 32'(4 * DEPTH1), 2'b00, 32'h0, 1'b0, got);
        txn(0, 1'b1, 1'b0, 32'h20, 2'b10, 32'h0, 1'b0, got);
        chk("word_after_errors", got, 32'h1122AA44);

        // Wait states, with wr_req wiggling after accept.
        txn(1, 1'b1, 1'b0, BASE1 + 32'h14, 2'b10, 32'h0, 1'b1, got);
        txn(1, 1'b1, 1'b0, BASE1 + 32'h14, 2'b10, 32'h0, 1'b0, got);

        // Reset during WAIT aborts a pending write.
        rd_req[1] = 1'b0; wr_req[1] = 1'b1; addr[1] = BASE1 + 32'h30; size[1] = 2'b10; wdata[1] = 32'h5;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        wr_req[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_rdy_in_reset", 32'(rdy_w[1]), 32'd0);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rdy_w[1]) seen = 1'b1;
        end
        $display("txn abort: dut1 rdy seen after reset=%0d", seen);
        chk("abort_no_rdy", 32'(seen), 32'd0);
        txn(1, 1'b1, 1'b0, BASE1 + 32'h30, 2'b10, 32'h0, 1'b0, got);

        // Random mix over both responders.
        for (int n = 0; n < 60; n++) begin
            d  = int'($urandom_range(0, 1));
            a  = base_of(d) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = base_of(d) + 32'(4 * depth_of(d)) + 32'($urandom_range(0, 7));
            sz = 2'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            if ($urandom_range(0, 15) == 0) begin rd = 1'b1; wr = 1'b1; end
            txn(d, rd, wr, a, sz, $urandom, 1'b0, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
